instr_cache: RTL and testbench
==============================

// Module: instr_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the fetch-stage PC and a
//  slower word-wide instruction memory. Hits return the instruction in the same
//  cycle, like the combinational i_mem. A miss raises stall to the hazard unit
//  (ORed into StallF/StallD) and runs a line refill through a req/ready handshake.
// PARAMETERS
//  DATA_WIDTH     32  instruction/memory word width
//  ADDRESS_WIDTH  16  byte-address width of pc_i and mem_addr
//  SETS           16  number of lines; power of 2, >=2
//  WORDS_PER_LINE 4   words per line; power of 2, >=2
// PORTS
//  clk       in   1              clock, rising edge
//  rst       in   1              asynchronous reset, active-high
//  pc_i      in   ADDRESS_WIDTH  fetch byte address (pcF)
//  fetch_en  in   1              fetch request valid this cycle
//  invalidate in  1              fence.i: clear all valid bits
//  instr     out  DATA_WIDTH     fetched instruction
//  stall     out  1              miss in progress; freeze F/D
//  mem_req   out  1              word read request to backing memory
//  mem_addr  out  ADDRESS_WIDTH  word-aligned byte address of request
//  mem_ready in   1              mem_rdata valid; request accepted
//  mem_rdata in   DATA_WIDTH     returned word
// BEHAVIOUR
//  Reset and clock are fixed: one clock clk; rst is asynchronous, active-high.
//  Address split: [1:0] ignored; next log2(WPL) bits select the word;
//    next log2(SETS) bits are the index; the remaining upper bits are the tag.
//  Reset: all valid=0, FSM=IDLE, beat=0, mem_req=0, stall=0, instr=32'h00000013.
//  hit = fetch_en & valid[idx] & tag[idx]==pc tag (combinational).
//  hit: instr = line word (combinational, 0-cycle latency), stall=0.
//  Otherwise instr = 32'h00000013 (NOP).
//  stall = fetch_en & ~hit, combinational, in every state.
//  FSM IDLE: on fetch_en & ~hit, latch index/tag, clear valid[idx], beat=0,
//    and go to FILL on the next edge.
//  FSM FILL: mem_req=1 and mem_addr = {tag,idx,beat,2'b00}.
//    Hold mem_req and mem_addr stable until mem_ready.
//    On mem_ready, write mem_rdata to word beat and increment beat.
//    On the last beat, write tag, set valid and return to IDLE.
//    The refetch then hits on the following cycle.
//  Fill order is sequential from word 0 with no critical-word-first.
//    Miss-to-hit latency is WPL*(ready latency) + 1 cycles.
//  pc_i may change during FILL (redirect or flush). The fill still completes to
//    the latched line, and stall follows the new pc_i lookup.
//  mem_ready outside FILL is ignored.
//  invalidate in IDLE: all valid bits clear at the next edge.
//    A lookup in the same cycle still uses the old valid bits.
//  invalidate in FILL: the fill completes but the line stays invalid.
//    The invalidate also clears all other lines.
//  rst mid-fill: the fill aborts immediately and mem_req drops asynchronously.
//    No line becomes valid.
//  Tag/data arrays have no reset; only the valid bits and the FSM reset.
// TESTING
//  1 Reset, fetch 0x0000, mem_ready=1 every cycle: requests go to 0x0,0x4,0x8,0xC;
//    stall is high for 5 cycles; then instr=mem word 0 with stall=0.
//  2 After test 1, fetch 0x0004/0x0008/0x000C: all hit with no mem_req, and the
//    instr values equal the filled words.
//  3 Conflict: fetch 0x0100 (index 0, tag 1) refills, then 0x0000 misses again.
//    A miss at 0x0040 (index 4) does not evict 0x0100.
//  4 mem_ready after 3 wait cycles per beat: mem_addr/mem_req stay stable while
//    waiting; stall lasts 4*4+1=17 cycles.
//  5 Assert rst after beat 2 of a fill: mem_req=0 at once; after reset the same pc
//    misses and refills from word 0.
//  6 invalidate with line 0 valid: the next fetch of 0x0000 misses. Invalidate
//    during a fill: the completed line misses afterwards.

Source files
------------

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache.
// Hits return the line word combinationally in the same cycle as the lookup.
// A miss raises stall and refills the whole line from word 0, one word per
// mem_ready handshake, before the refetch can hit.
module instr_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    input  logic                     fetch_en,
    input  logic                     invalidate,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic                     stall,
    output logic                     mem_req,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic                     mem_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int IDX_LSB   = 2 + WORD_BITS;
    localparam int TAG_LSB   = IDX_LSB + IDX_BITS;
    localparam int TAG_BITS  = ADDRESS_WIDTH - TAG_LSB;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

    typedef enum logic {
        IDLE,
        FILL
    } stateT;

    stateT state;

    // Storage: tag and data arrays carry no reset; only valid bits do.
    logic [TAG_BITS-1:0]   tagArr  [SETS];
    logic [DATA_WIDTH-1:0] dataArr [SETS*WORDS_PER_LINE];
    logic [SETS-1:0]       valid;

    // Latched refill target.
    logic [IDX_BITS-1:0]  fillIdx;
    logic [TAG_BITS-1:0]  fillTag;
    logic [WORD_BITS-1:0] beat;
    logic [WORD_BITS-1:0] nextBeat;
    logic                 invalSeen;

    // Lookup fields of the current fetch address.
    logic [WORD_BITS-1:0] pcWord;
    logic [IDX_BITS-1:0]  pcIdx;
    logic [TAG_BITS-1:0]  pcTag;
    logic                 hit;
    logic                 fillWrite;
    logic                 lastBeat;
    logic                 unusedPcBits;

    // Combinational lookup: hit, instruction mux and stall.
    always_comb begin
        pcWord       = pc_i[IDX_LSB-1:2];
        pcIdx        = pc_i[TAG_LSB-1:IDX_LSB];
        pcTag        = pc_i[ADDRESS_WIDTH-1:TAG_LSB];
        unusedPcBits = ^pc_i[1:0];
        hit          = fetch_en & valid[pcIdx] & (tagArr[pcIdx] == pcTag);
        instr        = hit ? dataArr[{pcIdx, pcWord}] : NOP;
        stall        = fetch_en & ~hit;
    end

    // Refill write strobe and beat bookkeeping.
    always_comb begin
        fillWrite = (state == FILL) & mem_ready;
        lastBeat  = (beat == WORD_BITS'(WORDS_PER_LINE - 1));
        nextBeat  = beat + 1'b1;
    end

    // Tag/data array writes as each refill beat is accepted.
    always_ff @(posedge clk) begin
        if (fillWrite) begin
            dataArr[{fillIdx, beat}] <= mem_rdata;
            if (lastBeat) begin
                tagArr[fillIdx] <= fillTag;
            end
        end
    end

    // Refill FSM with registered request outputs and valid-bit maintenance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            beat      <= '0;
            fillIdx   <= '0;
            fillTag   <= '0;
            invalSeen <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (stall) begin
                        fillIdx        <= pcIdx;
                        fillTag        <= pcTag;
                        valid[pcIdx]   <= 1'b0;
                        beat           <= '0;
                        invalSeen      <= 1'b0;
                        mem_req        <= 1'b1;
                        mem_addr       <= {pcTag, pcIdx, {WORD_BITS{1'b0}}, 2'b00};
                        state          <= FILL;
                    end
                end
                FILL: begin
                    if (invalidate) begin
                        invalSeen <= 1'b1;
                    end
                    if (mem_ready) begin
                        beat     <= nextBeat;
                        mem_addr <= {fillTag, fillIdx, nextBeat, 2'b00};
                        if (lastBeat) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                            // A fence.i seen at any point during the fill keeps the line invalid.
                            if (!(invalSeen | invalidate)) begin
                                valid[fillIdx] <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a flush overrides any per-line valid update above.
            if (invalidate) begin
                valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios with literal
// expectations, then randomized traffic against a line-residency model.
module tb_instr_cache;

    localparam int SETS = 16;
    localparam int WPL  = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        invalidate = 1'b0;
    logic [15:0] pc_i = '0;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int readyWait = 0;
    int waitCnt = 0;

    // Model: which tag is resident and valid in each set (-1 = none), plus the fill in flight.
    int resident [SETS];
    bit filling = 1'b0;
    int fTag = 0;
    int fIdx = 0;
    int fBeat = 0;
    bit fInval = 1'b0;

    logic        sStall;
    logic        sReq;
    logic [31:0] sInstr;
    logic [15:0] reqLog [$];

    instr_cache #(
        .DATA_WIDTH(32),
        .ADDRESS_WIDTH(16),
        .SETS(SETS),
        .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_i(pc_i),
        .fetch_en(fetch_en),
        .invalidate(invalidate),
        .instr(instr),
        .stall(stall),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Backing memory contents: a recognisable function of the word address.
    function automatic logic [31:0] memWord(input logic [15:0] a);
        return {16'hABCD, a[15:2], 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ready after readyWait idle cycles per beat, or randomly when readyWait<0.
    always @(posedge clk) begin
        #1;
        if (!mem_req) begin
            waitCnt   = 0;
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end else if (readyWait < 0 ? ($urandom_range(0, 2) == 0) : (waitCnt >= readyWait)) begin
            waitCnt   = 0;
            mem_ready = 1'b1;
            mem_rdata = memWord(mem_addr);
        end else begin
            waitCnt++;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Compare DUT outputs with the model, then advance the model to the next edge.
    task automatic modelStep();
        int idx;
        int tag;
        bit hit;
        sStall = stall;
        sReq   = mem_req;
        sInstr = instr;
        if (rst) begin
            foreach (resident[i]) resident[i] = -1;
            filling = 1'b0;
            chk("rst_stall", 32'(stall), 32'(fetch_en));
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_instr", instr, NOP);
            return;
        end
        idx = int'(pc_i[7:4]);
        tag = int'(pc_i[15:8]);
        hit = fetch_en && (resident[idx] == tag);
        chk("instr", instr, hit ? memWord(pc_i) : NOP);
        chk("stall", 32'(stall), 32'(fetch_en && !hit));
        chk("mem_req", 32'(mem_req), 32'(filling));
        if (filling) begin
            chk("mem_addr", 32'(mem_addr), 32'((fTag << 8) | (fIdx << 4) | (fBeat << 2)));
        end
        if (mem_req && mem_ready) reqLog.push_back(mem_addr);
        if (filling) begin
            if (invalidate) fInval = 1'b1;
            if (mem_ready) begin
                fBeat++;
                if (fBeat == WPL) begin
                    filling = 1'b0;
                    if (!fInval) resident[fIdx] = fTag;
                end
            end
        end else if (fetch_en && !hit) begin
            filling       = 1'b1;
            fTag          = tag;
            fIdx          = idx;
            fBeat         = 0;
            fInval        = 1'b0;
            resident[idx] = -1;
        end
        if (invalidate) begin
            foreach (resident[i]) resident[i] = -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    // Fetch an address until it hits; n = number of stalled cycles (bounded).
    task automatic fetchUntilHit(input logic [15:0] a, output int n);
        pc_i     = a;
        fetch_en = 1'b1;
        n        = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!sStall) break;
            n++;
        end
    endtask

    initial begin
        int n;
        foreach (resident[i]) resident[i] = -1;

        // Reset state
        #1;
        chk("reset_instr", instr, NOP);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // 1: cold miss at 0x0000, ready every cycle
        reqLog.delete();
        fetchUntilHit(16'h0000, n);
        chk("t1_stall_cycles", 32'(n), 32'd5);
        chk("t1_instr", sInstr, 32'hABCD0000);
        chk("t1_req_count", 32'(reqLog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < reqLog.size()) chk("t1_req_addr", 32'(reqLog[i]), 32'(i * 4));
        end

        // 2: remaining words of the line hit without requests
        for (int i = 1; i < 4; i++) begin
            pc_i = 16'(i * 4);
            tick();
            chk("t2_stall", 32'(sStall), 32'd0);
            chk("t2_mem_req", 32'(sReq), 32'd0);
            chk("t2_instr", sInstr, 32'hABCD0000 | 32'(i * 4));
        end

        // 3: conflict on index 0, unrelated index 4 does not evict
        fetchUntilHit(16'h0100, n);
        chk("t3_fill_0100", 32'(n), 32'd5);
        fetchUntilHit(16'h0040, n);
        chk("t3_fill_0040", 32'(n), 32'd5);
        fetchUntilHit(16'h0100, n);
        chk("t3_hit_0100", 32'(n), 32'd0);
        chk("t3_instr_0100", sInstr, 32'hABCD0100);
        fetchUntilHit(16'h0000, n);
        chk("t3_remiss_0000", 32'(n), 32'd5);

        // 4: three wait cycles per beat
        readyWait = 3;
        fetchUntilHit(16'h0200, n);
        chk("t4_stall_cycles", 32'(n), 32'd17);

        // 5: reset mid-fill after beat 2
        readyWait = 1;
        pc_i      = 16'h0300;
        fetch_en  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (filling && fBeat == 2) break;
        end
        chk("t5_req_before_rst", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_req_async_drop", 32'(mem_req), 32'd0);
        tick();
        rst = 1'b0;
        reqLog.delete();
        fetchUntilHit(16'h0300, n);
        chk("t5_refill_cycles", 32'(n), 32'd9);
        chk("t5_req_count", 32'(reqLog.size()), 32'd4);
        if (reqLog.size() > 0) chk("t5_first_addr", 32'(reqLog[0]), 32'h0300);

        // 6: invalidate in IDLE, then invalidate during a fill
        readyWait = 0;
        fetchUntilHit(16'h0000, n);
        invalidate = 1'b1;
        tick();
        chk("t6_same_cycle_hit", 32'(sStall), 32'd0);
        invalidate = 1'b0;
        fetchUntilHit(16'h0000, n);
        chk("t6_miss_after_inval", 32'(n), 32'd5);
        pc_i     = 16'h0400;
        fetch_en = 1'b1;
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        fetch_en   = 1'b0;
        repeat (6) tick();
        chk("t6_fill_done", 32'(filling), 32'd0);
        fetch_en = 1'b1;
        tick();
        chk("t6_inval_fill_miss", 32'(sStall), 32'd1);

        // Randomized traffic over a small address footprint
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                pc_i = 16'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
            end
            fetch_en   = ($urandom_range(0, 9) != 0);
            invalidate = ($urandom_range(0, 49) == 0);
            rst        = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) readyWait = int'($urandom_range(0, 3)) - 1;
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
